// File: rtl/binning_pkg.sv
// Shared encodings and helpers for the NxN video binner.
// The helper maps a bin_sel code to log2 of the block edge.
package binning_pkg;

    typedef enum logic [1:0] {
        BIN_1X1  = 2'd0,
        BIN_2X2  = 2'd1,
        BIN_4X4  = 2'd2,
        BIN_RSVD = 2'd3
    } bin_sel_t;

    // Per-channel accumulator growth over PIXEL_WIDTH: 16 pixels need 4 extra bits.
    localparam int ACC_EXTRA = 4;
    localparam int LAT       = 5;

    function automatic logic [1:0] bin_log2(input logic [1:0] sel);
        case (sel)
            BIN_2X2: return 2'd1;
            BIN_4X4: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/binning_linebuf.sv
// Simple dual-port line buffer with one-cycle synchronous read.
// It holds vertical partial sums between rows.
module binning_linebuf #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/binning_nxn.sv
// Run-time selectable 1x1/2x2/4x4 binner for de/hs/vs raster streams.
// Horizontal sums feed a read-modify-write line buffer; total latency is LAT clocks.
module binning_nxn
    import binning_pkg::*;
#(
    parameter int LINE_SIZE_MAX = 1024,
    parameter int PIXEL_WIDTH   = 8,
    parameter int CH_NUM        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    bin_sel,
    input  logic                          sum_mode,
    input  logic [CH_NUM*PIXEL_WIDTH-1:0] di_i,
    input  logic                          de_i,
    input  logic                          hs_i,
    input  logic                          vs_i,
    output logic [CH_NUM*PIXEL_WIDTH-1:0] do_o,
    output logic                          de_o,
    output logic                          hs_o,
    output logic                          vs_o,
    output logic [1:0]                    cfg_o
);

    localparam int ACC_W = PIXEL_WIDTH + ACC_EXTRA;
    localparam int HW    = PIXEL_WIDTH + 2;
    localparam int DEPTH = LINE_SIZE_MAX / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int CXW   = $clog2(LINE_SIZE_MAX) + 1;
    localparam int DW    = CH_NUM * PIXEL_WIDTH;
    localparam int SW    = CH_NUM * ACC_W;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << PIXEL_WIDTH) - 1);

    logic           hs_d, vs_d, cfg_sum, had_de;
    logic [1:0]     cfg_sel, ry;
    logic [CXW-1:0] cx;
    logic [CH_NUM*HW-1:0] acc;

    logic           vs_rise, line_start, sum_eff, pix, grp_done, first_row, last_row;
    logic [1:0]     sel_eff, lg, nmask, hpos, ry_eff;
    logic [CXW-1:0] cx_eff;
    logic [AW-1:0]  rd_addr, wr_addr;
    logic [SW-1:0]  gsum, rd_data, base, vsum, wr_data;
    logic           wr_en, rd_en;

    logic           s1_vld, s1_first, s1_last, s1_sum_mode, s1_fwd;
    logic [1:0]     s1_lg;
    logic [AW-1:0]  s1_ox;
    logic [SW-1:0]  s1_sum, s1_fwd_data;
    logic           s2_vld, s2_sum_mode, s3_vld, s4_vld;
    logic [1:0]     s2_lg;
    logic [SW-1:0]  s2_sum;
    logic [DW-1:0]  arith, s3_pix, s4_pix;
    logic [ACC_W-1:0] ch_sum;
    logic [LAT-1:0] hs_pipe, vs_pipe;

    // Effective column/row/config for the current pixel, honouring same-cycle line start or frame start.
    always_comb begin
        vs_rise    = vs_i & ~vs_d;
        line_start = hs_d & ~hs_i;
        sel_eff    = vs_rise ? bin_sel : cfg_sel;
        sum_eff    = vs_rise ? sum_mode : cfg_sum;
        lg         = bin_log2(sel_eff);
        nmask      = (lg == 2'd2) ? 2'd3 : ((lg == 2'd1) ? 2'd1 : 2'd0);
        cx_eff     = line_start ? '0 : cx;
        ry_eff     = ry;
        if (line_start && had_de) ry_eff = (ry == nmask) ? 2'd0 : ry + 2'd1;
        pix        = de_i & vs_i & (cx_eff < CXW'(LINE_SIZE_MAX));
        hpos       = cx_eff[1:0] & nmask;
        grp_done   = pix & (hpos == nmask);
        rd_addr    = AW'(cx_eff >> lg);
        first_row  = (ry_eff == 2'd0);
        last_row   = (ry_eff == nmask);
        rd_en      = grp_done & ~first_row;
        gsum       = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            gsum[c*ACC_W +: ACC_W] = ACC_W'(di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                + ((hpos == 2'd0) ? {ACC_W{1'b0}} : ACC_W'(acc[c*HW +: HW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            cfg_sel <= BIN_1X1;
            cfg_sum <= 1'b0;
            cx      <= '0;
            ry      <= '0;
            had_de  <= 1'b0;
            acc     <= '0;
        end else begin
            hs_d <= hs_i;
            vs_d <= vs_i;
            if (vs_rise) begin
                cfg_sel <= bin_sel;
                cfg_sum <= sum_mode;
            end
            if (!vs_i) begin
                cx     <= '0;
                ry     <= '0;
                had_de <= 1'b0;
                acc    <= '0;
            end else begin
                ry     <= ry_eff;
                had_de <= de_i | (had_de & ~line_start);
                cx     <= pix ? cx_eff + CXW'(1) : cx_eff;
                if (pix) begin
                    for (int c = 0; c < CH_NUM; c++) begin
                        acc[c*HW +: HW] <= (hpos == 2'd0)
                            ? HW'(di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH])
                            : acc[c*HW +: HW] + HW'(di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
                    end
                end
            end
        end
    end

    binning_linebuf #(.DEPTH(DEPTH), .WIDTH(SW), .AW(AW)) u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // A write landing on the address being read in the same cycle is forwarded, since the RAM returns old data.
    always_comb begin
        base    = s1_first ? '0 : (s1_fwd ? s1_fwd_data : rd_data);
        vsum    = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            vsum[c*ACC_W +: ACC_W] = base[c*ACC_W +: ACC_W] + s1_sum[c*ACC_W +: ACC_W];
        end
        wr_en   = s1_vld & ~s1_last;
        wr_addr = s1_ox;
        wr_data = vsum;
    end

    always_comb begin
        arith  = '0;
        ch_sum = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            ch_sum = s2_sum[c*ACC_W +: ACC_W];
            if (s2_sum_mode)
                arith[c*PIXEL_WIDTH +: PIXEL_WIDTH] = (ch_sum > SAT_MAX) ? {PIXEL_WIDTH{1'b1}}
                                                                         : ch_sum[PIXEL_WIDTH-1:0];
            else
                arith[c*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(ch_sum >> {s2_lg, 1'b0});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_sum_mode <= 1'b0;
            s1_lg <= '0; s1_ox <= '0; s1_sum <= '0; s1_fwd <= 1'b0; s1_fwd_data <= '0;
            s2_vld <= 1'b0; s2_sum_mode <= 1'b0; s2_lg <= '0; s2_sum <= '0;
            s3_vld <= 1'b0; s3_pix <= '0; s4_vld <= 1'b0; s4_pix <= '0;
            hs_pipe <= '0; vs_pipe <= '0;
            do_o <= '0; de_o <= 1'b0;
        end else begin
            s1_vld <= grp_done;
            if (grp_done) begin
                s1_sum      <= gsum;
                s1_ox       <= rd_addr;
                s1_first    <= first_row;
                s1_last     <= last_row;
                s1_lg       <= lg;
                s1_sum_mode <= sum_eff;
            end
            s1_fwd      <= wr_en && (wr_addr == rd_addr);
            s1_fwd_data <= wr_data;
            s2_vld <= s1_vld & s1_last;
            if (s1_vld) begin
                s2_sum      <= vsum;
                s2_lg       <= s1_lg;
                s2_sum_mode <= s1_sum_mode;
            end
            s3_vld  <= s2_vld;
            s3_pix  <= arith;
            s4_vld  <= s3_vld;
            s4_pix  <= s3_pix;
            hs_pipe <= {hs_pipe[LAT-2:0], hs_i};
            vs_pipe <= {vs_pipe[LAT-2:0], vs_i};
            de_o    <= s4_vld & vs_pipe[LAT-2];
            if (s4_vld) do_o <= s4_pix;
        end
    end

    assign hs_o  = hs_pipe[LAT-1];
    assign vs_o  = vs_pipe[LAT-1];
    assign cfg_o = cfg_sel;

endmodule
